car_collision_scan: RTL

- Consumer of the packed car-position bus driven by the multi-car controller (6 bits per car, car i at bits [i*6 +: 6]).
- On a start pulse it snapshots all car X/Y positions and the frog position, then scans one car per clock.
- Reports whether the frog overlaps any car, which car that is, and how many cars overlap.
- Sits between the car controller and the game-state logic: a hit costs a life.

---
 rtl/car_collision_scan_pkg.sv | 14 +
 rtl/car_collision_scan_lane_overlap.sv | 27 ++
 rtl/car_collision_scan.sv | 113 +++++++++++
 3 files changed

// File: rtl/car_collision_scan_pkg.sv
// Shared lane geometry and scan FSM encoding for the frog/car game blocks.
// Used by car_collision_scan and by the multi-car controller.
package car_collision_scan_pkg;
   localparam int c_POS_W          = 6;
   localparam int c_LANE_MAX_X     = 20;
   localparam int c_LANE_CAR_WIDTH = 2;
   localparam int c_NUM_CARS       = 10;
   localparam int c_IDX_WIDTH      = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;
endpackage

// File: rtl/car_collision_scan_lane_overlap.sv
// Combinational overlap test of one car against the frog on a wrapping lane.
module lane_overlap
   import car_collision_scan_pkg::*;
#(
   parameter int c_MAX_X     = c_LANE_MAX_X,
   parameter int c_CAR_WIDTH = c_LANE_CAR_WIDTH
) (
   input  logic [c_POS_W-1:0] i_Car_X,
   input  logic [c_POS_W-1:0] i_Car_Y,
   input  logic [c_POS_W-1:0] i_Frog_X,
   input  logic [c_POS_W-1:0] i_Frog_Y,
   output logic               o_Overlap
);
   logic [6:0] w_Fx, w_Cx, w_Dist;

   assign w_Fx = {1'b0, i_Frog_X};
   assign w_Cx = {1'b0, i_Car_X};

   // Distance from car X forward to frog X, wrapping past c_MAX_X back to 0.
   assign w_Dist = (w_Fx >= w_Cx) ? (w_Fx - w_Cx)
                                  : (w_Fx + 7'(c_MAX_X + 1) - w_Cx);

   assign o_Overlap = (i_Car_Y == i_Frog_Y)
                    && (w_Fx <= 7'(c_MAX_X))
                    && (w_Cx <= 7'(c_MAX_X))
                    && (w_Dist < 7'(c_CAR_WIDTH));
endmodule

// File: rtl/car_collision_scan.sv
// Snapshots car and frog positions on i_Start and scans one car per clock for overlap.
// Optional macro CAR_COLLISION_EARLY_EXIT_EN ends the scan at the first overlapping car.
module car_collision_scan
   import car_collision_scan_pkg::*;
#(
   parameter int NUM_CARS    = c_NUM_CARS,
   parameter int c_MAX_X     = c_LANE_MAX_X,
   parameter int c_CAR_WIDTH = c_LANE_CAR_WIDTH,
   parameter int IDX_WIDTH   = c_IDX_WIDTH
) (
   input  logic                        i_Clk,
   input  logic                        i_Rst_L,
   input  logic                        i_Start,
   input  logic [NUM_CARS*c_POS_W-1:0] i_Car_X,
   input  logic [NUM_CARS*c_POS_W-1:0] i_Car_Y,
   input  logic [c_POS_W-1:0]          i_Frog_X,
   input  logic [c_POS_W-1:0]          i_Frog_Y,
   output logic                        o_Busy,
   output logic                        o_Done,
   output logic                        o_Collision,
   output logic [IDX_WIDTH-1:0]        o_Hit_Car,
   output logic [IDX_WIDTH-1:0]        o_Hit_Count
);
   localparam logic [IDX_WIDTH-1:0] c_LAST = IDX_WIDTH'(NUM_CARS - 1);

   state_t                      r_State;
   logic [NUM_CARS*c_POS_W-1:0] r_Car_X, r_Car_Y;
   logic [c_POS_W-1:0]          r_Frog_X, r_Frog_Y;
   logic [IDX_WIDTH-1:0]        r_Idx, r_Acc_Car, r_Acc_Cnt;
   logic                        r_Acc_Hit;

   logic [c_POS_W-1:0]   w_Sel_X, w_Sel_Y;
   logic                 w_Hit, w_End, w_Hit_Nxt;
   logic [IDX_WIDTH-1:0] w_Car_Nxt, w_Cnt_Nxt;

   assign w_Sel_X = r_Car_X[r_Idx*c_POS_W +: c_POS_W];
   assign w_Sel_Y = r_Car_Y[r_Idx*c_POS_W +: c_POS_W];

   lane_overlap #(
      .c_MAX_X     (c_MAX_X),
      .c_CAR_WIDTH (c_CAR_WIDTH)
   ) u_lane_overlap (
      .i_Car_X   (w_Sel_X),
      .i_Car_Y   (w_Sel_Y),
      .i_Frog_X  (r_Frog_X),
      .i_Frog_Y  (r_Frog_Y),
      .o_Overlap (w_Hit)
   );

   // Accumulator values including the car evaluated this edge; the count saturates.
   assign w_Hit_Nxt = r_Acc_Hit | w_Hit;
   assign w_Car_Nxt = (w_Hit && !r_Acc_Hit) ? r_Idx : r_Acc_Car;
   assign w_Cnt_Nxt = (w_Hit && (r_Acc_Cnt != '1)) ? r_Acc_Cnt + 1'b1 : r_Acc_Cnt;

`ifdef CAR_COLLISION_EARLY_EXIT_EN
   assign w_End = (r_Idx == c_LAST) || w_Hit;
`else
   assign w_End = (r_Idx == c_LAST);
`endif

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_State     <= IDLE;
         r_Car_X     <= '0;
         r_Car_Y     <= '0;
         r_Frog_X    <= '0;
         r_Frog_Y    <= '0;
         r_Idx       <= '0;
         r_Acc_Car   <= '0;
         r_Acc_Cnt   <= '0;
         r_Acc_Hit   <= 1'b0;
         o_Busy      <= 1'b0;
         o_Done      <= 1'b0;
         o_Collision <= 1'b0;
         o_Hit_Car   <= '0;
         o_Hit_Count <= '0;
      end else begin
         o_Done <= 1'b0;
         case (r_State)
            IDLE: begin
               if (i_Start) begin
                  r_Car_X   <= i_Car_X;
                  r_Car_Y   <= i_Car_Y;
                  r_Frog_X  <= i_Frog_X;
                  r_Frog_Y  <= i_Frog_Y;
                  r_Idx     <= '0;
                  r_Acc_Car <= '0;
                  r_Acc_Cnt <= '0;
                  r_Acc_Hit <= 1'b0;
                  o_Busy    <= 1'b1;
                  r_State   <= SCAN;
               end
            end
            SCAN: begin
               if (w_End) begin
                  o_Done      <= 1'b1;
                  o_Collision <= w_Hit_Nxt;
                  o_Hit_Car   <= w_Car_Nxt;
                  o_Hit_Count <= w_Cnt_Nxt;
                  o_Busy      <= 1'b0;
                  r_State     <= IDLE;
               end else begin
                  r_Acc_Hit <= w_Hit_Nxt;
                  r_Acc_Car <= w_Car_Nxt;
                  r_Acc_Cnt <= w_Cnt_Nxt;
                  r_Idx     <= r_Idx + 1'b1;
               end
            end
            default: r_State <= IDLE;
         endcase
      end
   end
endmodule
